// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry instruction queue between the IF stage and decode.
// Each entry holds PC, instruction, fetch exception code and delay-slot flag.
// Both sides use valid/ready handshakes.
// Flush empties the queue.
// Flush_keep1 keeps only the oldest entry, which is the branch delay slot.
module if_id_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int EXC_W  = 5,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              Flush_keep1,
  input  logic              In_valid,
  output logic              In_ready,
  input  logic [DATA_W-1:0] Pc,
  input  logic [DATA_W-1:0] Instr,
  input  logic [EXC_W-1:0]  exccode,
  input  logic              delay,
  output logic              Out_valid,
  input  logic              Out_ready,
  output logic [DATA_W-1:0] Pc_ID,
  output logic [DATA_W-1:0] Instr_ID,
  output logic [EXC_W-1:0]  exccode_ID,
  output logic              delay_ID,
  output logic [CNT_W-1:0]  Count
);

  localparam int PTR_W = $clog2(DEPTH);

  // Entry storage; not reset because the head outputs are masked while empty.
  logic [DATA_W-1:0] pc_mem_q    [DEPTH];
  logic [DATA_W-1:0] instr_mem_q [DEPTH];
  logic [EXC_W-1:0]  exc_mem_q   [DEPTH];
  logic              dly_mem_q   [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en_s;
  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;

  // Full/empty come only from the registered count.
  // In_ready therefore has no path from Out_ready.
  assign full_s    = (count_q == CNT_W'(DEPTH));
  assign empty_s   = (count_q == {CNT_W{1'b0}});
  assign In_ready  = ~full_s;
  assign Out_valid = ~empty_s;
  assign push_s    = In_valid & ~full_s;
  assign pop_s     = ~empty_s & Out_ready;
  assign Count     = count_q;

  // Next-state pointers and count; flush beats flush_keep1 beats normal traffic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wr_en_s  = 1'b0;
    if (Flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = {CNT_W{1'b0}};
    end else if (Flush_keep1) begin
      if (empty_s) begin
        count_d = {CNT_W{1'b0}};
      end else if (!pop_s) begin
        // Retain the head (delay slot) and drop everything behind it.
        wr_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d  = CNT_W'(1);
      end else if ((count_q == CNT_W'(1)) && push_s) begin
        // Delay slot leaves now; the incoming entry becomes the only entry.
        wr_en_s  = 1'b1;
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        count_d  = CNT_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        wr_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d  = {CNT_W{1'b0}};
      end
    end else begin
      if (push_s) begin
        wr_en_s  = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push_s && !pop_s) begin
        count_d = count_q + CNT_W'(1);
      end else if (!push_s && pop_s) begin
        count_d = count_q - CNT_W'(1);
      end else begin
        count_d = count_q;
      end
    end
  end

  // Pointer and occupancy registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Write the accepted fetch entry into the slot at the write pointer.
  always_ff @(posedge Clk) begin
    if (wr_en_s) begin
      pc_mem_q[wr_ptr_q]    <= Pc;
      instr_mem_q[wr_ptr_q] <= Instr;
      exc_mem_q[wr_ptr_q]   <= exccode;
      dly_mem_q[wr_ptr_q]   <= delay;
    end
  end

  // Head entry to decode; an empty queue presents an all-zero nop bubble.
  always_comb begin
    Pc_ID      = {DATA_W{1'b0}};
    Instr_ID   = {DATA_W{1'b0}};
    exccode_ID = {EXC_W{1'b0}};
    delay_ID   = 1'b0;
    if (!empty_s) begin
      Pc_ID      = pc_mem_q[rd_ptr_q];
      Instr_ID   = instr_mem_q[rd_ptr_q];
      exccode_ID = exc_mem_q[rd_ptr_q];
      delay_ID   = dly_mem_q[rd_ptr_q];
    end else begin
      Pc_ID      = {DATA_W{1'b0}};
      Instr_ID   = {DATA_W{1'b0}};
      exccode_ID = {EXC_W{1'b0}};
      delay_ID   = 1'b0;
    end
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register.
- A DEPTH-entry instruction queue decouples fetch from decode using valid/ready handshakes on both sides.
- Each entry carries PC, instruction, fetch exception code and delay-slot flag.
- Supports full flush (interrupt/exception) and branch flush that preserves the delay slot. Sits between the IF stage and the decode/GRF/forwarding logic.

Parameters:
- DATA_W, 32, width of PC and instruction fields.
- DEPTH, 4, queue entries; power of two, ≥2.
- EXC_W, 5, exception-code width.
- CNT_W, $clog2(DEPTH+1), width of Count.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- Flush  in  1  discard all entries (interrupt/exception redirect).
- Flush_keep1  in  1  discard all entries except the oldest (branch taken; head is the delay slot).
- In_valid  in  1  fetch presents an entry.
- In_ready  out  1  queue can accept an entry this cycle.
- Pc  in  DATA_W  fetch PC.
- Instr  in  DATA_W  fetched instruction.
- exccode  in  EXC_W  fetch exception code (0 = none).
- delay  in  1  entry is in a delay slot.
- Out_valid  out  1  head entry valid.
- Out_ready  in  1  decode consumes head (decode not stalled).
- Pc_ID  out  DATA_W  head PC.
- Instr_ID  out  DATA_W  head instruction.
- exccode_ID  out  EXC_W  head exception code.
- delay_ID  out  1  head delay flag.
- Count  out  CNT_W  occupied entries.

Behaviour:
- Storage and pointers:
  - Circular buffer with write pointer, read pointer and Count, all registered.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Handshake signals:
  - push = In_valid & In_ready.
  - pop = Out_valid & Out_ready.
  - In_ready = (Count != DEPTH). It has no combinational path from Out_ready, so a push is refused when full even if a pop occurs that cycle.
  - Out_valid = (Count != 0).
- Head outputs:
  - When Out_valid=1, Pc_ID/Instr_ID/exccode_ID/delay_ID are driven from the head entry, read combinationally from storage.
  - When Out_valid=0, all four are forced to 0. Instr_ID=0 is a nop bubble.
- Latency:
  - An entry pushed in cycle N is visible at the head no earlier than cycle N+1.
  - There is no same-cycle fall-through.
- Push and pop together:
  - Simultaneous push and pop with 0<Count<DEPTH leaves Count unchanged; both pointers advance.
- Flush=1 (highest priority):
  - Next cycle Count=0 and read pointer = write pointer.
  - Any same-cycle push or pop is ignored; the popped value still counts as consumed this cycle.
  - Flush_keep1 is ignored while Flush=1.
- Flush_keep1=1 with Flush=0:
  - If Count=0: queue stays empty and any same-cycle push is dropped.
  - If Count≥1 and pop=0: the head is retained; next cycle Count=1 and write pointer = read pointer+1. A same-cycle push is dropped.
  - If Count≥1 and pop=1: the head is consumed as delay slot; the remainder is discarded. A same-cycle push is kept only if Count was 1 (it is then the sole entry); otherwise next cycle Count=0.
- Reset asserted:
  - Asynchronously sets Count=0, both pointers=0, all head outputs=0, Out_valid=0, In_ready=1.
  - Storage contents need no reset because the outputs are masked while empty.
- Reset mid-operation: all in-flight entries are lost with no partial state. The first push after deassertion lands in entry 0.

Test Plan:
- Reset low, then high → Count=0, Out_valid=0, In_ready=1, Instr_ID=0. Push Pc=0x3000, Instr=0x24010005, Out_ready=0 → next cycle Out_valid=1, Pc_ID=0x3000, Instr_ID=0x24010005, Count=1.
- Fill to full with Out_ready=0, pushing PCs 0x3000, 0x3004, 0x3008, 0x300C → In_ready=0, Count=4. Push 0x3010 with Out_ready=1 → push refused, Count=3. Drain order is 0x3004, 0x3008, 0x300C.
- Wrap-around: stream 10 entries with In_valid=Out_ready=1 continuously → Count stays 1 after the first cycle. Pop sequence equals push sequence with no gaps and no duplicates.
- Flush with Count=3 while pushing 0x4180 → next cycle Count=0, Out_valid=0, Pc_ID=0. The following push of 0x4180 appears as head.
- Flush_keep1 with Count=3, head Pc=0x3004 (delay=1), Out_ready=0 → next cycle Count=1, Pc_ID=0x3004, delay_ID=1. The same cycle's push is dropped.
- Flush_keep1 with Count=1, pop=1, push Pc=0x3100 → next cycle Count=1, Pc_ID=0x3100. Exception entry exccode=4 propagates to exccode_ID=4 unchanged.
